// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Fills the instruction ROM from a little-endian byte stream
//               (16-bit word count header, then 32-bit words) and holds the
//               CPU in reset until the image is written.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int ADDR_W       = 32,
    parameter int MAX_WORDS    = 256,
    parameter int CPU_RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              code_en,
    output logic              data_en,
    output logic              done,
    output logic              error
);

    localparam int HOLD_W = (CPU_RST_HOLD > 1) ? $clog2(CPU_RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(CPU_RST_HOLD - 1);
    localparam logic [31:0]       c_max_words = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_HOLD  = 3'd5,
        S_RUN   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_count;
    logic [15:0]       r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [31:0]       r_wdata;

    logic              w_accept;
    logic [15:0]       w_count_hdr;
    logic              w_word_last;

    assign w_accept    = in_valid && in_ready;
    // Full count as it will stand once the high header byte is taken.
    assign w_count_hdr = {in_data, r_count[7:0]};
    assign w_word_last = ((r_word_idx + 16'd1) == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        cpu_rst     = 1'b1;
        code_en     = 1'b0;
        data_en     = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        mem_addr    = ADDR_W'({r_word_idx, 2'b00});
        mem_wdata   = r_wdata;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_HDR0;
            end
            S_HDR0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_HDR1;
                end
            end
            S_HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_count_hdr == 16'd0) begin
                        w_state_nxt = S_HOLD;
                    end else if ({16'd0, w_count_hdr} > c_max_words) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we      = 1'b1;
                w_state_nxt = w_word_last ? S_HOLD : S_DATA;
            end
            S_HOLD: begin
                code_en = 1'b1;
                data_en = 1'b1;
                if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                code_en = 1'b1;
                data_en = 1'b1;
                done    = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_hold_cnt <= '0;
            r_wdata    <= 32'd0;
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        r_count[7:0] <= in_data;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_count[15:8] <= in_data;
                    end
                end
                S_DATA: begin
                    // Only the addressed lane changes; the rest keep the prior word.
                    if (w_accept) begin
                        r_wdata[{r_byte_idx, 3'b000} +: 8] <= in_data;
                        r_byte_idx                         <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                end
                S_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader; image outcomes come from
//               a stream-level reference model (header parse + word slicing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int ADDR_W       = 32;
    localparam int MAX_WORDS    = 256;
    localparam int CPU_RST_HOLD = 4;

    typedef logic [7:0] u8_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              code_en;
    logic              data_en;
    logic              done;
    logic              error;

    boot_loader #(
        .ADDR_W       (ADDR_W),
        .MAX_WORDS    (MAX_WORDS),
        .CPU_RST_HOLD (CPU_RST_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .code_en   (code_en),
        .data_en   (data_en),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observation of the DUT, cleared whenever reset is seen.
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int cyc_no, n_acc, last_evt, hold_cyc, fall_cyc, ready_viol;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_addr.delete();
            mon_data.delete();
            cyc_no     = 0;
            n_acc      = 0;
            last_evt   = 0;
            hold_cyc   = 0;
            fall_cyc   = -1;
            ready_viol = 0;
        end else begin
            cyc_no++;
            if (in_valid && in_ready) begin
                n_acc++;
                last_evt = cyc_no;
            end
            if (mem_we) begin
                mon_addr.push_back(32'(mem_addr));
                mon_data.push_back(mem_wdata);
                last_evt = cyc_no;
                if (in_ready) ready_viol++;
            end
            if (cpu_rst && code_en) hold_cyc++;
            if (done && fall_cyc < 0) fall_cyc = cyc_no;
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // pct < 0 selects in_valid toggling every other cycle.
    task automatic drive_bytes(input u8_t q[$], input int pct);
        int  idx;
        bit  acc;
        idx = 0;
        for (int c = 0; c < 3000 && idx < q.size() && !(done || error); c++) begin
            in_data  = q[idx];
            in_valid = (pct < 0) ? ((c % 2) == 0) : (int'($urandom_range(0, 99)) < pct);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
    endtask

    task automatic run_image(input string name, input u8_t q[$], input int pct);
        int  cnt, need, nw;
        bit  exp_err;
        logic [31:0] exp_word;
        cnt     = int'(q[0]) + 256 * int'(q[1]);
        exp_err = (cnt > MAX_WORDS);
        nw      = exp_err ? 0 : cnt;
        need    = exp_err ? 2 : 2 + 4 * cnt;

        do_reset();
        drive_bytes(q, pct);
        // Keep offering junk into the terminal state.
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 200 && !(done || error); c++) begin
            @(posedge clk);
            #1;
        end
        check({name, ":terminal"}, 64'(done || error), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        check({name, ":n_writes"}, 64'(mon_addr.size()), 64'(nw));
        for (int i = 0; i < nw && i < mon_addr.size(); i++) begin
            exp_word = {q[2+4*i+3], q[2+4*i+2], q[2+4*i+1], q[2+4*i]};
            check($sformatf("%s:addr%0d", name, i), 64'(mon_addr[i]), 64'(4 * i));
            check($sformatf("%s:data%0d", name, i), 64'(mon_data[i]), 64'(exp_word));
        end
        check({name, ":accepted"},   64'(n_acc),      64'(need));
        check({name, ":ready_in_we"}, 64'(ready_viol), 64'd0);
        check({name, ":done"},        64'(done),       64'(!exp_err));
        check({name, ":error"},       64'(error),      64'(exp_err));
        check({name, ":cpu_rst"},     64'(cpu_rst),    64'(exp_err));
        check({name, ":code_en"},     64'(code_en),    64'(!exp_err));
        check({name, ":data_en"},     64'(data_en),    64'(!exp_err));
        check({name, ":in_ready"},    64'(in_ready),   64'd0);
        if (!exp_err) begin
            check({name, ":hold_cycles"}, 64'(hold_cyc), 64'(CPU_RST_HOLD));
            check({name, ":release_lat"}, 64'(fall_cyc - last_evt), 64'(CPU_RST_HOLD + 1));
        end else begin
            check({name, ":hold_cycles"}, 64'(hold_cyc), 64'd0);
        end
    endtask

    initial begin
        u8_t img1[$];
        u8_t q[$];
        int  cnt;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:cpu_rst",   64'(cpu_rst),   64'd1);
        check("rst:in_ready",  64'(in_ready),  64'd0);
        check("rst:mem_we",    64'(mem_we),    64'd0);
        check("rst:code_en",   64'(code_en),   64'd0);
        check("rst:data_en",   64'(data_en),   64'd0);
        check("rst:done",      64'(done),      64'd0);
        check("rst:error",     64'(error),     64'd0);
        check("rst:mem_addr",  64'(mem_addr),  64'd0);
        check("rst:mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle:in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("hdr0:in_ready", 64'(in_ready), 64'd1);

        img1 = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image("t1_two_words", img1, 100);
        run_image("t2_empty", '{8'h00, 8'h00}, 100);
        run_image("t3_too_big", '{8'h01, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88}, 100);
        run_image("t4_toggle", img1, -1);

        // Reset in the middle of word 1 must drop the partial word at once.
        do_reset();
        drive_bytes('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB}, 100);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5:cpu_rst_async",  64'(cpu_rst),   64'd1);
        check("t5:in_ready_async", 64'(in_ready),  64'd0);
        check("t5:wdata_async",    64'(mem_wdata), 64'd0);
        run_image("t5_reload", '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 100);

        for (int t = 0; t < 6; t++) begin
            cnt = (t == 5) ? int'($urandom_range(257, 2000)) : int'($urandom_range(0, 6));
            q.delete();
            q.push_back(8'(cnt));
            q.push_back(8'(cnt >> 8));
            if (cnt <= MAX_WORDS) begin
                for (int b = 0; b < 4 * cnt; b++) q.push_back(8'($urandom));
            end
            for (int b = 0; b < 4; b++) q.push_back(8'($urandom));
            run_image($sformatf("rand%0d", t), q, int'($urandom_range(25, 100)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
